// File: rtl/fifo_to_sd_pkg.sv
// Shared types and defaults for the FIFO-to-SD block writer.
// Optional build macro used by the top: FIFO_TO_SD_UNDERRUN_CNT_EN.
package fifo_to_sd_pkg;

  typedef enum logic [1:0] {
    IDLE               = 2'd0,
    REQUEST_WRITE_WAIT = 2'd1,
    WRITE_BYTES        = 2'd2
  } state_t;

  localparam int         BLOCK_BYTES_DEF = 512;
  localparam logic [7:0] PAD_BYTE_DEF    = 8'h00;

endpackage

// File: rtl/fifo_byte_stager.sv
// One-byte prefetch stage in front of a 1-cycle-latency FIFO: pops a byte
// ahead of the SD byte strobe so it is ready when the controller asks for it.
module fifo_byte_stager (
  input  logic       clk_in,
  input  logic       reset_in,
  input  logic       enable,
  input  logic       consume_evt,
  input  logic       take,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_dout,
  output logic       fifo_read_enable,
  output logic [7:0] staged_byte,
  output logic       staged_valid
);

  logic       rd_en_q, rd_en_d;
  logic       capture_q, capture_d;
  logic       fetch_pending_q, fetch_pending_d;
  logic       staged_valid_q, staged_valid_d;
  logic [7:0] staged_byte_q, staged_byte_d;

  // fetch_pending covers both the pop cycle and the data-return cycle, so at
  // most one byte is ever in flight or staged.
  always_comb begin
    rd_en_d         = 1'b0;
    capture_d       = rd_en_q;
    fetch_pending_d = fetch_pending_q;
    staged_valid_d  = staged_valid_q;
    staged_byte_d   = staged_byte_q;

    if (take) begin
      staged_valid_d = 1'b0;
    end

    if (capture_q) begin
      staged_byte_d   = fifo_dout;
      staged_valid_d  = 1'b1;
      fetch_pending_d = 1'b0;
    end

    if (enable && !staged_valid_q && !fetch_pending_q && !fifo_empty && !consume_evt) begin
      rd_en_d         = 1'b1;
      fetch_pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      rd_en_q         <= 1'b0;
      capture_q       <= 1'b0;
      fetch_pending_q <= 1'b0;
      staged_valid_q  <= 1'b0;
      staged_byte_q   <= 8'h00;
    end else begin
      rd_en_q         <= rd_en_d;
      capture_q       <= capture_d;
      fetch_pending_q <= fetch_pending_d;
      staged_valid_q  <= staged_valid_d;
      staged_byte_q   <= staged_byte_d;
    end
  end

  assign fifo_read_enable = rd_en_q;
  assign staged_byte      = staged_byte_q;
  assign staged_valid     = staged_valid_q;

endmodule

// File: rtl/fifo_to_sd.sv
// Drains a byte FIFO into the SD controller block-write port, one block per start.
// Optional macro FIFO_TO_SD_UNDERRUN_CNT_EN adds a saturating padded-byte counter.
module fifo_to_sd
  import fifo_to_sd_pkg::*;
#(
  parameter int         BLOCK_BYTES = BLOCK_BYTES_DEF,
  parameter logic [7:0] PAD_BYTE    = PAD_BYTE_DEF
) (
  input  logic        clk_in,
  input  logic        reset_in,
  input  logic        store_fifo,
  input  logic [31:0] write_addr,
  input  logic        sd_write_accepted,
  input  logic        sd_ready_for_next_byte,
  input  logic [7:0]  fifo_dout,
  input  logic        fifo_empty,
  output logic        request_sd_write,
  output logic [31:0] sd_addr,
  output logic [7:0]  sd_din,
  output logic        fifo_read_enable,
  output logic        busy,
`ifdef FIFO_TO_SD_UNDERRUN_CNT_EN
  output logic [15:0] underrun_count,
`endif
  output logic        done
);

  localparam int             CW       = $clog2(BLOCK_BYTES + 1);
  localparam logic [CW-1:0]  LAST_IDX = CW'(BLOCK_BYTES - 1);

  state_t         state_q, state_d;
  logic           request_q, request_d;
  logic [31:0]    addr_q, addr_d;
  logic [7:0]     din_q, din_d;
  logic           done_q, done_d;
  logic [CW-1:0]  count_q, count_d;
  logic           ready_old_q, ready_old_d;
  logic           consume_evt, take;
  logic           staged_valid;
  logic [7:0]     staged_byte;
`ifdef FIFO_TO_SD_UNDERRUN_CNT_EN
  logic [15:0]    underrun_q, underrun_d;
`endif

  assign ready_old_d = sd_ready_for_next_byte;
  assign consume_evt = sd_ready_for_next_byte && !ready_old_q;
  assign take        = consume_evt && (state_q == WRITE_BYTES);

  fifo_byte_stager u_stager (
    .clk_in           (clk_in),
    .reset_in         (reset_in),
    .enable           (state_q != IDLE),
    .consume_evt      (consume_evt),
    .take             (take),
    .fifo_empty       (fifo_empty),
    .fifo_dout        (fifo_dout),
    .fifo_read_enable (fifo_read_enable),
    .staged_byte      (staged_byte),
    .staged_valid     (staged_valid)
  );

  always_comb begin
    state_d   = state_q;
    request_d = request_q;
    addr_d    = addr_q;
    din_d     = din_q;
    done_d    = 1'b0;
    count_d   = count_q;
`ifdef FIFO_TO_SD_UNDERRUN_CNT_EN
    underrun_d = underrun_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (store_fifo) begin
          state_d   = REQUEST_WRITE_WAIT;
          request_d = 1'b1;
          addr_d    = write_addr;
          count_d   = '0;
`ifdef FIFO_TO_SD_UNDERRUN_CNT_EN
          underrun_d = 16'h0000;
`endif
        end
      end
      REQUEST_WRITE_WAIT: begin
        if (sd_write_accepted) begin
          request_d = 1'b0;
          state_d   = WRITE_BYTES;
        end
      end
      WRITE_BYTES: begin
        // A strobe that finds nothing staged (empty FIFO or fetch still in flight) gets padding.
        if (consume_evt) begin
          din_d   = staged_valid ? staged_byte : PAD_BYTE;
          count_d = count_q + CW'(1);
`ifdef FIFO_TO_SD_UNDERRUN_CNT_EN
          if (!staged_valid && (underrun_q != 16'hFFFF)) begin
            underrun_d = underrun_q + 16'd1;
          end
`endif
          if (count_q == LAST_IDX) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    ready_old_q <= ready_old_d;
    if (reset_in) begin
      state_q   <= IDLE;
      request_q <= 1'b0;
      addr_q    <= 32'h0;
      din_q     <= PAD_BYTE;
      done_q    <= 1'b0;
      count_q   <= '0;
`ifdef FIFO_TO_SD_UNDERRUN_CNT_EN
      underrun_q <= 16'h0000;
`endif
    end else begin
      state_q   <= state_d;
      request_q <= request_d;
      addr_q    <= addr_d;
      din_q     <= din_d;
      done_q    <= done_d;
      count_q   <= count_d;
`ifdef FIFO_TO_SD_UNDERRUN_CNT_EN
      underrun_q <= underrun_d;
`endif
    end
  end

  assign request_sd_write = request_q;
  assign sd_addr          = addr_q;
  assign sd_din           = din_q;
  assign done             = done_q;
  assign busy             = (state_q != IDLE);
`ifdef FIFO_TO_SD_UNDERRUN_CNT_EN
  assign underrun_count   = underrun_q;
`endif

endmodule
